// File: rtl/adc78h90_pkg.sv
// Shared constants and state type for the ADC78H90 serial responder.
// Frame layout: 16 bits per frame, 12-bit data, channel address in receive bits [13:11].
package adc78h90_pkg;

  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 12;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_MSB   = 13;
  localparam int ADDR_LSB   = 11;
  localparam int ADDR_W     = ADDR_MSB - ADDR_LSB + 1;
  localparam int CNT_W      = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/adc_spi_sync.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised copy.
// Edges are suppressed until the chain has been refilled from the pin after reset.
module adc_spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   fill;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      fill  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
      fill  <= {fill[STAGES-1:0], 1'b1};
    end
  end

  // A level held across reset release must not look like an edge against the reset value.
  assign q    = chain[STAGES-1];
  assign rise = fill[STAGES] & q & ~prev;
  assign fall = fill[STAGES] & ~q & prev;

endmodule

// File: rtl/adc78h90_responder.sv
// Behavioural stand-in for an ADC78H90: returns the channel addressed in the previous
// frame MSB-first on MISO while capturing the next address from MOSI.
module adc78h90_responder
  import adc78h90_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     SCLK,
  input  logic                     nCS,
  input  logic                     MOSI,
  output logic                     MISO,
  output logic                     miso_oe,
  input  logic [NUM_CH*DATA_W-1:0] ain_values,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ADDR_RISES = CNT_W'(FRAME_BITS - ADDR_LSB);

  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic sclk_lvl_unused, ncs_lvl_unused;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  state_t                state;
  logic [FRAME_BITS-1:0] tx;
  logic [FRAME_BITS-1:0] rx;
  logic [CNT_W-1:0]      rise_cnt;
  logic [3:0]            rx_idx;
  logic                  rx_unused;

  adc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (SCLK),
    .q     (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  adc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (nCS),
    .q     (ncs_lvl_unused),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  // Same depth as the SCLK chain so MOSI stays aligned with the detected rising edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Bit k of the frame always lands at rx[15-k], so [13:11] hold the address for any count >= 5.
  assign rx_idx    = 4'(FRAME_BITS - 1) - rise_cnt[3:0];
  assign rx_unused = ^{rx[FRAME_BITS-1:ADDR_MSB+1], rx[ADDR_LSB-1:0]};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx         <= '0;
      rx         <= '0;
      rise_cnt   <= '0;
      miso_oe    <= 1'b0;
      cur_addr   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ncs_fall) begin
            state    <= ST_SHIFT;
            tx       <= {{(FRAME_BITS-DATA_W){1'b0}}, ain_values[int'(cur_addr)*DATA_W +: DATA_W]};
            rx       <= '0;
            rise_cnt <= '0;
            miso_oe  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // Frame end takes priority over any SCLK edge detected in the same cycle.
          if (ncs_rise) begin
            state      <= ST_IDLE;
            tx         <= '0;
            miso_oe    <= 1'b0;
            frame_done <= (rise_cnt == CNT_FULL);
            frame_err  <= (rise_cnt < CNT_FULL);
            if (rise_cnt >= ADDR_RISES) cur_addr <= rx[ADDR_MSB:ADDR_LSB];
          end else if (sclk_rise) begin
            if (rise_cnt < CNT_FULL) begin
              rx[rx_idx] <= mosi_s;
              rise_cnt   <= rise_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            tx <= {tx[FRAME_BITS-2:0], 1'b0};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign MISO = tx[FRAME_BITS-1];

endmodule

// File: tb/tb_adc78h90_responder.sv
// Bench for adc78h90_responder: an initiator at clock/4 drives frames while a frame-level
// model predicts the MISO stream, address pipeline and end-of-frame pulses.
module tb_adc78h90_responder;
  import adc78h90_pkg::*;

  logic                     clock = 1'b0;
  logic                     rst_n;
  logic                     SCLK, nCS, MOSI;
  logic                     MISO, miso_oe;
  logic [NUM_CH*DATA_W-1:0] ain_values;
  logic [ADDR_W-1:0]        cur_addr;
  logic                     frame_done, frame_err;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Frame-level model state.
  logic              settled = 1'b0;
  logic              exp_oe  = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [0:0]        exp_q[$];

  adc78h90_responder #(.SYNC_STAGES(2)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .SCLK       (SCLK),
    .nCS        (nCS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .miso_oe    (miso_oe),
    .ain_values (ain_values),
    .cur_addr   (cur_addr),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clock) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
    if (settled) begin
      check("cur_addr", 32'(cur_addr), 32'(exp_addr));
      check("miso_oe", 32'(miso_oe), 32'(exp_oe));
    end
    if (rst_n === 1'b1 && miso_oe === 1'b0) check("miso_idle", 32'(MISO), 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic sclk_bit(input logic d, output logic s);
    MOSI = d;
    SCLK = 1'b0;
    repeat (3) @(negedge clock);
    s = MISO;
    SCLK = 1'b1;
    @(negedge clock);
    SCLK = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] ctrl, input int nrise, input bit poke,
                           output logic [15:0] got);
    logic [15:0] word;
    logic        s;
    int          d0, e0;
    word = {4'b0000, ain_values[int'(exp_addr)*DATA_W +: DATA_W]};
    for (int i = 0; i < nrise; i++) exp_q.push_back((i < 16) ? word[15-i] : 1'b0);
    got = '0;
    settled = 1'b0;
    nCS = 1'b0;
    repeat (3) @(negedge clock);
    exp_oe  = 1'b1;
    settled = 1'b1;
    for (int i = 0; i < nrise; i++) begin
      sclk_bit((i < 16) ? ctrl[15-i] : 1'b0, s);
      if (i < 16) got[15-i] = s;
      check("miso_bit", 32'(s), 32'(exp_q.pop_front()));
      if (poke && i == 4) ain_values = {$urandom, $urandom, $urandom};
    end
    repeat (3) @(negedge clock);
    d0 = done_cnt;
    e0 = err_cnt;
    settled = 1'b0;
    nCS = 1'b1;
    repeat (5) @(negedge clock);
    check("frame_done_count", 32'(done_cnt - d0), (nrise >= 16) ? 32'd1 : 32'd0);
    check("frame_err_count", 32'(err_cnt - e0), (nrise < 16) ? 32'd1 : 32'd0);
    if (nrise >= 5) exp_addr = ctrl[13:11];
    exp_oe  = 1'b0;
    settled = 1'b1;
    MOSI = 1'b0;
  endtask

  function automatic logic [15:0] ctrl_word(input logic [2:0] a);
    logic [15:0] w;
    w = 16'($urandom);
    w[13:11] = a;
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] got;
    logic        s;
    int          d0, e0, nr;

    rst_n = 1'b0;
    SCLK = 1'b0;
    nCS  = 1'b1;
    MOSI = 1'b0;
    ain_values = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clock);
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_oe", 32'(miso_oe), 32'd0);
    check("reset_addr", 32'(cur_addr), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clock);
    settled = 1'b1;

    // Hand-computed pins for the model.
    ain_values[11:0] = 12'hABC;
    run_frame(ctrl_word(3'd3), 16, 1'b0, got);
    check("first_frame_word", 32'(got), 32'h0ABC);
    check("first_frame_addr", 32'(cur_addr), 32'd3);

    ain_values[3*DATA_W +: DATA_W] = 12'h123;
    run_frame(ctrl_word(3'd5), 16, 1'b0, got);
    check("second_frame_word", 32'(got), 32'h0123);
    check("second_frame_addr", 32'(cur_addr), 32'd5);

    for (int a = 0; a < 6; a++) begin
      ain_values = {$urandom, $urandom, $urandom};
      run_frame(ctrl_word(3'(a)), 16, 1'b0, got);
    end

    // Short frames: 4 rises keep the address, 7 rises take it.
    run_frame(ctrl_word(3'd2), 4, 1'b0, got);
    check("short4_addr", 32'(cur_addr), 32'd5);
    run_frame(ctrl_word(3'd6), 7, 1'b0, got);
    check("short7_addr", 32'(cur_addr), 32'd6);

    run_frame(ctrl_word(3'd1), 20, 1'b0, got);
    check("long_frame_addr", 32'(cur_addr), 32'd1);

    // Reset in the middle of a frame with nCS held low.
    settled = 1'b0;
    nCS = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 8; i++) sclk_bit(1'($urandom), s);
    d0 = done_cnt;
    e0 = err_cnt;
    rst_n = 1'b0;
    @(negedge clock);
    check("midreset_miso", 32'(MISO), 32'd0);
    check("midreset_oe", 32'(miso_oe), 32'd0);
    check("midreset_addr", 32'(cur_addr), 32'd0);
    rst_n = 1'b1;
    exp_addr = '0;
    exp_oe   = 1'b0;
    settled  = 1'b1;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 6; i++) sclk_bit(1'($urandom), s);
    repeat (4) @(negedge clock);
    check("midreset_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    nCS = 1'b1;
    repeat (4) @(negedge clock);
    ain_values[11:0] = 12'h5A5;
    run_frame(ctrl_word(3'd4), 16, 1'b0, got);
    check("post_reset_word", 32'(got), 32'h05A5);

    // Randomised frames, some with ain_values changing mid-frame.
    repeat (30) begin
      nr = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(0, 20));
      run_frame(16'($urandom), nr, 1'($urandom_range(0, 1)), got);
    end

    settled = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
